// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, free-running sample-tick
// divider, 3-sample majority vote at mid-bit, false-start rejection and a
// ready/valid holding register with parity/frame/overrun reporting.
module uart_rx_os #(
    parameter int CLKS_PER_SAMPLE = 1,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] CNT_LO   = SW'(M - 1);
    localparam logic [SW-1:0] CNT_MID  = SW'(M);
    localparam logic [SW-1:0] CNT_DEC  = SW'(M + 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state, state_nx;
    logic                 rx_meta, rxs;
    logic                 tick;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 samp_a, samp_b;
    logic                 maj, is_dec, is_wrap;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, par_exp;
    logic                 perr, ferr;
    logic                 frame_done;

    // Two-flop synchroniser for the asynchronous line, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    generate
        if (CLKS_PER_SAMPLE == 1) begin : g_tick_direct
            // clk is already the oversample clock
            always_comb tick = 1'b1;
        end else begin : g_tick_div
            localparam int DW = $clog2(CLKS_PER_SAMPLE);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_SAMPLE - 1);
            logic [DW-1:0] div_cnt;

            // Free-running divider producing one tick every CLKS_PER_SAMPLE clks
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    div_cnt <= '0;
                else if (div_cnt == DIV_LAST)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end

            // Tick on the last divider count
            always_comb tick = (div_cnt == DIV_LAST);
        end
    endgenerate

    // Majority of the two captured samples and the live sample at M+1
    always_comb begin
        maj     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        is_dec  = (scnt == CNT_DEC);
        is_wrap = (scnt == CNT_LAST);
        par_exp = (PARITY == 2) ? ~par_acc : par_acc;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state logic; all transitions happen on sample ticks
    always_comb begin
        state_nx = state;
        if (tick) begin
            case (state)
                S_IDLE:      if (!rxs) state_nx = S_START;
                S_START: begin
                    if (is_dec && maj)
                        state_nx = S_IDLE;
                    else if (is_wrap)
                        state_nx = S_DATA;
                end
                S_DATA:      if (is_wrap && bit_idx == BIT_LAST)
                                 state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                S_PARITY:    if (is_wrap) state_nx = S_STOP;
                S_STOP:      if (is_dec && stop_idx == STOP_LAST)
                                 state_nx = (ferr | ~maj) ? S_WAIT_IDLE : S_IDLE;
                S_WAIT_IDLE: if (rxs) state_nx = S_IDLE;
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag and frame-complete strobe
    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = tick && (state == S_STOP) && is_dec && (stop_idx == STOP_LAST);
    end

    // Bit timing, sampling, shift register and per-frame error accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else if (tick) begin
            if (scnt == CNT_LO)  samp_a <= rxs;
            if (scnt == CNT_MID) samp_b <= rxs;
            case (state)
                S_IDLE: begin
                    scnt     <= rxs ? '0 : CNT_ONE;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_acc  <= 1'b0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                end
                S_WAIT_IDLE: scnt <= '0;
                default: begin
                    scnt <= is_wrap ? '0 : scnt + 1'b1;
                    if (state == S_DATA && is_dec) begin
                        shreg[bit_idx] <= maj;
                        par_acc        <= par_acc ^ maj;
                    end
                    if (state == S_DATA && is_wrap)   bit_idx  <= bit_idx + 1'b1;
                    if (state == S_PARITY && is_dec)  perr     <= (maj != par_exp);
                    if (state == S_STOP && is_dec)    ferr     <= ferr | ~maj;
                    if (state == S_STOP && is_wrap)   stop_idx <= 1'b1;
                end
            endcase
        end
    end

    // Holding register: load on completion if free or being drained, else flag overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr;
                    frame_err  <= ferr | ~maj;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receiver configurations driven with directed and
// random frames; expected words come from a frame-level model of the line.
module tb_uart_rx_os;

    localparam int OS_T  [3] = '{16, 8, 16};
    localparam int CPS_T [3] = '{1, 3, 1};
    localparam int PAR_T [3] = '{0, 1, 2};
    localparam int NST_T [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_v [3];
    logic       rdy  [3];
    logic [7:0] rxd  [3];
    logic       rv   [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       ov   [3];
    logic       bsy  [3];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned start_cyc = 0;
    int unsigned rise0    = 0;
    int unsigned vhigh0   = 0;
    int unsigned ov_cnt [3] = '{0, 0, 0};
    logic        rv0_q    = 1'b0;
    logic [11:0] got_q [$];

    uart_rx_os #(.CLKS_PER_SAMPLE(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx_v[0]), .rx_data(rxd[0]), .rx_valid(rv[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bsy[0]));

    uart_rx_os #(.CLKS_PER_SAMPLE(3), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx_v[1]), .rx_data(rxd[1]), .rx_valid(rv[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bsy[1]));

    uart_rx_os #(.CLKS_PER_SAMPLE(1), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .rx(rx_v[2]), .rx_data(rxd[2]), .rx_valid(rv[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bsy[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every accepted word, count overrun pulses, time dut0's valid rise
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rv[i] && rdy[i]) got_q.push_back({2'(i), pe[i], fe[i], rxd[i]});
            if (ov[i]) ov_cnt[i] <= ov_cnt[i] + 1;
        end
        if (rv[0]) vhigh0 <= vhigh0 + 1;
        if (rv[0] && !rv0_q) rise0 <= cyc;
        rv0_q <= rv[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected {parity_err, frame_err} of a frame, from the line-level rules
    function automatic logic [1:0] model_flags(input int idx, input logic [7:0] d,
                                               input logic pbit, input logic [1:0] stops);
        logic perr, ferr;
        case (PAR_T[idx])
            1:       perr = (pbit != (^d));
            2:       perr = (pbit != ~(^d));
            default: perr = 1'b0;
        endcase
        ferr = (stops[0] == 1'b0) || (NST_T[idx] == 2 && stops[1] == 1'b0);
        return {perr, ferr};
    endfunction

    // Drive one frame on line idx; optional 1-tick high spike at the centre of
    // frame bit spike_bit; optional extra low time after the stop bits.
    task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stops, input int spike_bit, input int tail_low);
        logic lv [$];
        int   bitc, sp_lo;
        bitc  = OS_T[idx] * CPS_T[idx];
        sp_lo = (OS_T[idx] / 2) * CPS_T[idx];
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (PAR_T[idx] != 0) lv.push_back(pbit);
        for (int s = 0; s < NST_T[idx]; s++) lv.push_back(stops[s]);
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int b = 0; b < lv.size(); b++) begin
            for (int c = 0; c < bitc; c++) begin
                rx_v[idx] = (b == spike_bit && c >= sp_lo && c < sp_lo + CPS_T[idx]) ? 1'b1 : lv[b];
                @(posedge clk); #1;
            end
        end
        if (tail_low > 0) begin
            rx_v[idx] = 1'b0;
            repeat (tail_low) begin @(posedge clk); #1; end
        end
        rx_v[idx] = 1'b1;
        repeat (2 * bitc) begin @(posedge clk); #1; end
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [7:0] d,
                               input logic pbit, input logic [1:0] stops);
        logic [11:0] w;
        logic [1:0]  fl;
        int          n = 0;
        fl = model_flags(idx, d, pbit, stops);
        while (got_q.size() == 0 && n < 4000) begin @(posedge clk); #1; n++; end
        check({tag, "_present"}, got_q.size() != 0, 1);
        if (got_q.size() != 0) begin
            w = got_q.pop_front();
            check({tag, "_unit"}, w[11:10], idx);
            check({tag, "_data"}, w[7:0], d);
            check({tag, "_perr"}, w[9], fl[1]);
            check({tag, "_ferr"}, w[8], fl[0]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog sim time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned vbase, ovbase;
        logic [7:0]  d5a;
        logic [7:0]  rd;
        logic        rp;
        logic [1:0]  rs;

        for (int i = 0; i < 3; i++) begin rx_v[i] = 1'b1; rdy[i] = 1'b1; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rv[0], 0);
        check("rst_busy", bsy[0], 0);
        check("rst_data", rxd[0], 0);
        check("rst_flags", {pe[0], fe[0], ov[0]}, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 8N1 0xA5: latency and single-cycle valid
        vbase = vhigh0;
        send_frame(0, 8'hA5, 1'b0, 2'b11, -1, 0);
        check("a5_latency", rise0 - start_cyc, 156);
        check("a5_valid_cycles", vhigh0 - vbase, 1);
        expect_word("a5", 0, 8'hA5, 1'b0, 2'b11);

        // Parity handling
        send_frame(1, 8'h07, 1'b0, 2'b11, -1, 0);
        expect_word("even_bad", 1, 8'h07, 1'b0, 2'b11);
        send_frame(1, 8'h07, 1'b1, 2'b11, -1, 0);
        expect_word("even_ok", 1, 8'h07, 1'b1, 2'b11);
        send_frame(2, 8'h07, 1'b0, 2'b11, -1, 0);
        expect_word("odd_ok", 2, 8'h07, 1'b0, 2'b11);

        // False start: 5 low ticks
        @(posedge clk); #1;
        rx_v[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rx_v[0] = 1'b1;
        check("glitch_busy_hi", bsy[0], 1);
        repeat (20) begin @(posedge clk); #1; end
        check("glitch_busy_lo", bsy[0], 0);
        check("glitch_no_word", got_q.size(), 0);

        // Spike in the middle of data bit 3 is outvoted
        send_frame(0, 8'h00, 1'b0, 2'b11, 4, 0);
        expect_word("spike", 0, 8'h00, 1'b0, 2'b11);

        // Frame error followed by a long low line, then a clean frame
        send_frame(0, 8'h3C, 1'b0, 2'b00, -1, 40);
        check("brk_one_word", got_q.size(), 1);
        expect_word("brk", 0, 8'h3C, 1'b0, 2'b00);
        send_frame(0, 8'h81, 1'b0, 2'b11, -1, 0);
        expect_word("after_brk", 0, 8'h81, 1'b0, 2'b11);

        // Overrun with the holder full
        rdy[0] = 1'b0;
        ovbase = ov_cnt[0];
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, 0);
        check("ovr_no_pulse_first", ov_cnt[0] - ovbase, 0);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1, 0);
        check("ovr_pulse", ov_cnt[0] - ovbase, 1);
        check("ovr_held_data", rxd[0], 8'h11);
        check("ovr_held_valid", rv[0], 1);
        rdy[0] = 1'b1;
        @(posedge clk); #1;
        check("ovr_drain", rv[0], 0);
        expect_word("ovr_word", 0, 8'h11, 1'b0, 2'b11);

        // Async reset mid-DATA with a word held
        rdy[0] = 1'b0;
        send_frame(0, 8'hC3, 1'b0, 2'b10, -1, 0);
        check("pre_rst_valid", rv[0], 1);
        d5a = 8'h5A;
        @(posedge clk); #1;
        for (int c = 0; c < 16 * 4 + 5; c++) begin
            rx_v[0] = (c < 16) ? 1'b0 : d5a[(c - 16) / 16];
            @(posedge clk); #1;
        end
        check("pre_rst_busy", bsy[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", rv[0], 0);
        check("mid_rst_data", rxd[0], 0);
        check("mid_rst_flags", {pe[0], fe[0], ov[0]}, 0);
        check("mid_rst_busy", bsy[0], 0);
        rx_v[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy[0] = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("post_rst_no_stale", got_q.size(), 0);
        send_frame(0, 8'h5A, 1'b0, 2'b11, -1, 0);
        expect_word("post_rst", 0, 8'h5A, 1'b0, 2'b11);

        // Random frames on all three configurations
        for (int u = 0; u < 3; u++) begin
            for (int k = 0; k < 10; k++) begin
                rd = 8'($urandom_range(0, 255));
                rp = 1'($urandom_range(0, 1));
                rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                send_frame(u, rd, rp, rs, -1, 0);
                expect_word("rand", u, rd, rp, rs);
            end
        end
        check("rand_no_extra", got_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
